// File: rtl/memory_write_buffer_if.sv
// Core-side load/store handshake bundle for memory_write_buffer.
// The master is the load/store stage. The slave is the buffer.
interface memory_write_buffer_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_data_valid;
    logic                  empty;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        input  wr_ready, rd_ready, rd_data, rd_data_valid, empty
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
        output wr_ready, rd_ready, rd_data, rd_data_valid, empty
    );
endinterface

// File: rtl/memory_write_buffer.sv
// Store buffer in front of a single-port RAM. Writes are queued and drained when the port is
// free. Reads share the port and forward the youngest buffered data for their address.
module memory_write_buffer #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    memory_write_buffer_if.slave  core,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_rw,
    input  logic [DATA_WIDTH-1:0] mem_dout
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]      head_q, tail_q;
    logic [PTR_W:0]        count_q;

    logic                  rd_valid_q, hit_q;
    logic [DATA_WIDTH-1:0] fwd_q;

    logic                  full, push, drain, rd_accept;
    logic                  hit_d;
    logic [DATA_WIDTH-1:0] fwd_d;
    logic [PTR_W-1:0]      idx;

    assign full = (count_q == (PTR_W+1)'(DEPTH));

    always_comb begin
        rd_accept = core.rd_valid && !full && !rst;
        // A full buffer always wins the port so reads cannot starve the drain.
        drain     = !rst && (full || (!core.rd_valid && count_q != '0));
        push      = core.wr_valid && !full;
        mem_rw    = drain;
        mem_a     = '0;
        mem_din   = '0;
        if (drain) begin
            mem_a   = addr_q[head_q];
            mem_din = data_q[head_q];
        end else if (rd_accept) begin
            mem_a = core.rd_addr;
        end
    end

    // Scan oldest to youngest so the last match, the youngest write, wins.
    always_comb begin
        hit_d = 1'b0;
        fwd_d = '0;
        idx   = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if (((PTR_W+1)'(k) < count_q) && (addr_q[idx] == core.rd_addr)) begin
                hit_d = 1'b1;
                fwd_d = data_q[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            hit_q      <= 1'b0;
            fwd_q      <= '0;
        end else begin
            if (push) begin
                addr_q[tail_q] <= core.wr_addr;
                data_q[tail_q] <= core.wr_data;
                tail_q         <= tail_q + 1'b1;
            end
            if (drain) begin
                head_q <= head_q + 1'b1;
            end
            case ({push, drain})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            rd_valid_q <= rd_accept;
            hit_q      <= hit_d;
            fwd_q      <= fwd_d;
        end
    end

    assign core.wr_ready      = !full;
    assign core.rd_ready      = !full && !rst;
    assign core.empty         = (count_q == '0);
    assign core.rd_data_valid = rd_valid_q;
    assign core.rd_data       = !rd_valid_q ? '0 : (hit_q ? fwd_q : mem_dout);
endmodule
